br_flow_reg_rev_skid: RTL and testbench

// - Reverse-style flow register generalised to a Depth-entry skid buffer: push_ready is a flop
//   (breaks the ready timing path); valid/data have a zero-cycle bypass when the buffer is empty.
// - Depth=1 is cycle-equivalent to the single-entry reverse register. Depth>1 absorbs bursts of
//   pop-side backpressure. An occupancy output is provided for credit/debug use.
// - Sits on ready-critical valid/ready links between pipeline stages.
//

---
 rtl/br_flow_reg_rev_skid.sv | 105 ++++++++++
 tb/tb_br_flow_reg_rev_skid.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/br_flow_reg_rev_skid.sv
// Reverse-style flow register with a Depth-entry skid buffer.
// push_ready is registered; valid/data bypass the storage when it is empty.
module br_flow_reg_rev_skid #(
  parameter int Width = 1,
  parameter int Depth = 1,
  parameter bit EnableCoverPushBackpressure = 1,
  parameter bit EnableAssertPushValidStability = EnableCoverPushBackpressure,
  parameter bit EnableAssertPushDataStability = EnableAssertPushValidStability,
  parameter bit EnableAssertFinalNotValid = 1,
  localparam int CountW = $clog2(Depth + 1)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              push_ready,
  input  logic              push_valid,
  input  logic [Width-1:0]  push_data,
  input  logic              pop_ready,
  output logic              pop_valid,
  output logic [Width-1:0]  pop_data,
  output logic [CountW-1:0] occupancy
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  if (Width < 1) begin : gen_width_check
    $error("Width must be at least 1");
  end
  if (Depth < 1) begin : gen_depth_check
    $error("Depth must be at least 1");
  end

  logic [Width-1:0]  mem_q [Depth];
  logic [CountW-1:0] occ_q, occ_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic              push_ready_q, push_ready_d;
  logic              empty, push, pop, bypass_pop, wr_en, rd_en;

  function automatic logic [PtrW-1:0] incPtr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  // An empty buffer forwards the push side directly; once anything is held,
  // every new push goes through storage so ordering is kept.
  always_comb begin
    empty      = (occ_q == '0);
    push       = push_valid & push_ready_q;
    pop_valid  = push_valid | ~empty;
    pop_data   = empty ? push_data : mem_q[rd_ptr_q];
    pop        = pop_valid & pop_ready;
    bypass_pop = push & pop & empty;
    wr_en      = push & ~bypass_pop;
    rd_en      = pop & ~empty;
    occ_d      = occ_q + CountW'(wr_en) - CountW'(rd_en);
    wr_ptr_d   = wr_en ? incPtr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = rd_en ? incPtr(rd_ptr_q) : rd_ptr_q;
    push_ready_d = (occ_d != CountW'(Depth));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q        <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      push_ready_q <= 1'b1;
    end else begin
      occ_q        <= occ_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      push_ready_q <= push_ready_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign push_ready = push_ready_q;
  assign occupancy  = occ_q;

  if (EnableCoverPushBackpressure) begin : gen_cover_bp
    coverPushBackpressure: cover property (@(posedge clk) disable iff (rst)
      push_valid && !push_ready);
  end

  if (EnableAssertPushValidStability) begin : gen_assert_valid
    assertPushValidStable: assert property (@(posedge clk) disable iff (rst)
      (push_valid && !push_ready) |=> push_valid);
  end

  if (EnableAssertPushDataStability) begin : gen_assert_data
    assertPushDataStable: assert property (@(posedge clk) disable iff (rst)
      (push_valid && !push_ready) |=> $stable(push_data));
  end

  if (EnableAssertFinalNotValid) begin : gen_assert_final
    final begin
      assertFinalEmpty: assert (occupancy == '0 && !pop_valid);
    end
  end

endmodule

// File: tb/tb_br_flow_reg_rev_skid.sv
// Self-checking bench: a Depth=3 and a Depth=1 instance, each compared every
// cycle against a queue-style reference model of the skid buffer.
module tb_br_flow_reg_rev_skid;

  logic       clk = 1'b0;
  logic       rst;
  logic       pv [2];
  logic [7:0] pd [2];
  logic       pr [2];
  logic       pushReady [2];
  logic       popValid [2];
  logic [7:0] popData [2];
  logic [1:0] occ3;
  logic       occ1;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a plain array holding the buffered entries per instance.
  logic [7:0] mMem [2][256];
  int         mHead [2];
  int         mCnt [2];
  logic       mRdy [2];
  bit         pending [2];
  int         depthOf [2] = '{3, 1};

  always #5 clk = ~clk;

  br_flow_reg_rev_skid #(.Width(8), .Depth(3)) dut3 (
    .clk(clk), .rst(rst),
    .push_ready(pushReady[0]), .push_valid(pv[0]), .push_data(pd[0]),
    .pop_ready(pr[0]), .pop_valid(popValid[0]), .pop_data(popData[0]),
    .occupancy(occ3)
  );

  br_flow_reg_rev_skid #(.Width(8), .Depth(1)) dut1 (
    .clk(clk), .rst(rst),
    .push_ready(pushReady[1]), .push_valid(pv[1]), .push_data(pd[1]),
    .pop_ready(pr[1]), .pop_valid(popValid[1]), .pop_data(popData[1]),
    .occupancy(occ1)
  );

  function automatic logic [31:0] occOf(input int i);
    return (i == 0) ? 32'(occ3) : 32'(occ1);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample at the falling edge and compare every output with the model.
  task automatic settle();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      logic       expValid;
      logic [7:0] expData;
      expValid = pv[i] || (mCnt[i] != 0);
      expData  = (mCnt[i] != 0) ? mMem[i][mHead[i]] : pd[i];
      checkOutput($sformatf("occupancy[%0d]", i), occOf(i), 32'(mCnt[i]));
      checkOutput($sformatf("push_ready[%0d]", i), 32'(pushReady[i]), 32'(mRdy[i]));
      checkOutput($sformatf("pop_valid[%0d]", i), 32'(popValid[i]), 32'(expValid));
      if (expValid) begin
        checkOutput($sformatf("pop_data[%0d]", i), 32'(popData[i]), 32'(expData));
      end
      checkOutput($sformatf("occ_bound[%0d]", i), 32'(occOf(i) <= 32'(depthOf[i])), 32'd1);
    end
    checkOutput("d1_ready_vs_occ", 32'(pushReady[1]), 32'(!occ1));
  endtask

  // Apply this cycle's transfer to the model, then cross the rising edge.
  task automatic advance();
    for (int i = 0; i < 2; i++) begin
      bit doPush, doPop;
      if (rst) begin
        mCnt[i] = 0;
        mHead[i] = 0;
        mRdy[i] = 1'b1;
        pending[i] = 1'b0;
      end else begin
        doPush = pv[i] && mRdy[i];
        doPop  = (pv[i] || mCnt[i] != 0) && pr[i];
        pending[i] = pv[i] && !mRdy[i];
        if (mCnt[i] == 0) begin
          if (doPush && !pr[i]) begin
            mMem[i][mHead[i]] = pd[i];
            mCnt[i] = 1;
          end
        end else begin
          if (doPop) begin
            mHead[i] = (mHead[i] + 1) % 256;
            mCnt[i]--;
          end
          if (doPush) begin
            mMem[i][(mHead[i] + mCnt[i]) % 256] = pd[i];
            mCnt[i]++;
          end
        end
        mRdy[i] = (mCnt[i] != depthOf[i]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int i, input int pvPct, input int prPct);
    if (!pending[i]) begin
      pv[i] = ($urandom_range(99) < pvPct);
      pd[i] = 8'($urandom);
    end
    pr[i] = ($urandom_range(99) < prPct);
  endtask

  task automatic drive0(input logic v, input logic [7:0] d, input logic r);
    pv[0] = v;
    pd[0] = d;
    pr[0] = r;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      pv[i] = 1'b0; pd[i] = 8'h00; pr[i] = 1'b0;
      mHead[i] = 0; mCnt[i] = 0; mRdy[i] = 1'b1; pending[i] = 1'b0;
    end
    @(posedge clk);
    #1;

    // Reset state
    settle();
    checkOutput("reset_occ3", occOf(0), 32'd0);
    checkOutput("reset_ready3", 32'(pushReady[0]), 32'd1);
    advance();
    rst = 1'b0;
    pv[1] = 1'b0; pr[1] = 1'b1;

    // Bypass
    drive0(1'b1, 8'h11, 1'b1);
    settle();
    checkOutput("bypass_data0", 32'(popData[0]), 32'h11);
    advance();
    drive0(1'b1, 8'h22, 1'b1);
    settle();
    checkOutput("bypass_data1", 32'(popData[0]), 32'h22);
    checkOutput("bypass_occ", occOf(0), 32'd0);
    advance();

    // Fill
    drive0(1'b1, 8'hA0, 1'b0); settle(); advance();
    checkOutput("fill_occ1", occOf(0), 32'd1);
    drive0(1'b1, 8'hA1, 1'b0); settle(); advance();
    checkOutput("fill_occ2", occOf(0), 32'd2);
    drive0(1'b1, 8'hA2, 1'b0); settle(); advance();

    // Full with a held push, then one pop
    drive0(1'b1, 8'hA3, 1'b0);
    settle();
    checkOutput("full_occ", occOf(0), 32'd3);
    checkOutput("full_ready", 32'(pushReady[0]), 32'd0);
    checkOutput("full_head", 32'(popData[0]), 32'hA0);
    advance();
    drive0(1'b1, 8'hA3, 1'b1);
    settle();
    checkOutput("drain_pop_a0", 32'(popData[0]), 32'hA0);
    advance();
    drive0(1'b1, 8'hA3, 1'b0);
    settle();
    checkOutput("drain_ready_back", 32'(pushReady[0]), 32'd1);
    checkOutput("drain_head_a1", 32'(popData[0]), 32'hA1);
    advance();
    drive0(1'b0, 8'h00, 1'b1);
    settle();
    checkOutput("drain_occ3", occOf(0), 32'd3);
    checkOutput("drain_pop_a1", 32'(popData[0]), 32'hA1);
    advance();
    settle();
    checkOutput("drain_pop_a2", 32'(popData[0]), 32'hA2);
    advance();
    settle();
    checkOutput("drain_pop_a3", 32'(popData[0]), 32'hA3);
    advance();
    settle();
    checkOutput("drain_empty", occOf(0), 32'd0);
    advance();

    // Reset with two entries held
    drive0(1'b1, 8'hB0, 1'b0); settle(); advance();
    drive0(1'b1, 8'hB1, 1'b0); settle(); advance();
    drive0(1'b0, 8'h00, 1'b0);
    rst = 1'b1;
    settle();
    checkOutput("pre_reset_occ", occOf(0), 32'd2);
    advance();
    rst = 1'b0;
    settle();
    checkOutput("post_reset_occ", occOf(0), 32'd0);
    checkOutput("post_reset_ready", 32'(pushReady[0]), 32'd1);
    checkOutput("post_reset_valid", 32'(popValid[0]), 32'd0);
    advance();

    // Random bursts on both instances; pop-side pressure changes per burst
    for (int b = 0; b < 10; b++) begin
      int prPct;
      int len;
      prPct = (b % 3 == 0) ? 10 : ((b % 3 == 1) ? 50 : 90);
      len = $urandom_range(20, 8);
      for (int c = 0; c < len; c++) begin
        applyStimulus(0, 75, prPct);
        applyStimulus(1, 60, 50);
        settle();
        advance();
      end
    end
    for (int c = 0; c < 200; c++) begin
      applyStimulus(0, 50, 50);
      applyStimulus(1, $urandom_range(90, 20), $urandom_range(90, 20));
      settle();
      advance();
    end

    // Drain both, letting any held push complete first
    for (int c = 0; c < 8; c++) begin
      applyStimulus(0, 0, 100);
      applyStimulus(1, 0, 100);
      settle();
      advance();
    end
    settle();
    checkOutput("final_occ3", occOf(0), 32'd0);
    checkOutput("final_occ1", occOf(1), 32'd0);
    checkOutput("final_valid3", 32'(popValid[0]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
